// File: rtl/conv_kernel_engine.sv
// Sequential SIZE x SIZE convolution engine: LANES taps per cycle are accumulated,
// then the sum is normalised by an arithmetic right shift and clamped to the pixel range.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// ACCUM | LANES taps multiplied and added per cycle, C cycles
// NORM  | shift, clamp and register the result
// OUT   | result presented until out_ready
module conv_kernel_engine #(
    parameter int SIZE   = 3,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int LANES  = 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SIZE*SIZE*PIX_W-1:0]    window,
    input  logic [SIZE*SIZE*COEF_W-1:0]   kernel,
    input  logic [3:0]                    shift,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIX_W-1:0]              out_pixel,
    output logic                          overflow,
    output logic                          busy
);

    localparam int N     = SIZE * SIZE;
    localparam int C     = (N + LANES - 1) / LANES;
    localparam int ACC_W = PIX_W + COEF_W + $clog2(N) + 1;
    localparam int PRD_W = PIX_W + COEF_W + 1;
    localparam int IDX_W = $clog2(N + LANES) + 1;
    localparam int CNT_W = $clog2(C + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

    state_t state, state_nxt;

    logic [PIX_W-1:0]         pix_q  [N];
    logic signed [COEF_W-1:0] coef_q [N];
    logic [3:0]               shift_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [IDX_W-1:0]         idx;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     last_tap;
    logic [PIX_W-1:0]         lane_pix;
    logic signed [COEF_W-1:0] lane_coef;
    logic signed [PRD_W-1:0]  pix_ext;
    logic signed [PRD_W-1:0]  coef_ext;
    logic signed [PRD_W-1:0]  lane_prod;
    logic [PIX_W-1:0]         norm_pixel;
    logic                     norm_ovf;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready && !clear;
    assign last_tap  = (cnt == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCUM;
            ACCUM:   if (last_tap) state_nxt = NORM;
            NORM:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Each lane muxes its tap out of the register array; taps past N select zero.
    always_comb begin
        lane_sum  = '0;
        lane_pix  = '0;
        lane_coef = '0;
        pix_ext   = '0;
        coef_ext  = '0;
        lane_prod = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_pix  = '0;
            lane_coef = '0;
            for (int j = 0; j < N; j++) begin
                if (IDX_W'(j) == idx + IDX_W'(l)) begin
                    lane_pix  = pix_q[j];
                    lane_coef = coef_q[j];
                end
            end
            pix_ext   = {{COEF_W{1'b0}}, 1'b0, lane_pix};
            coef_ext  = {{(PIX_W + 1){lane_coef[COEF_W-1]}}, lane_coef};
            lane_prod = pix_ext * coef_ext;
            lane_sum  = lane_sum + {{(ACC_W - PRD_W){lane_prod[PRD_W-1]}}, lane_prod};
        end
    end

    always_comb begin
        acc_shr    = acc >>> shift_q;
        norm_pixel = acc_shr[PIX_W-1:0];
        norm_ovf   = 1'b0;
        if (acc_shr[ACC_W-1]) begin
            norm_pixel = '0;
            norm_ovf   = 1'b1;
        end else if (|acc_shr[ACC_W-2:PIX_W]) begin
            norm_pixel = '1;
            norm_ovf   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int j = 0; j < N; j++) begin
                pix_q[j]  <= '0;
                coef_q[j] <= '0;
            end
            shift_q   <= '0;
            acc       <= '0;
            idx       <= '0;
            cnt       <= '0;
            out_pixel <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            idx      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int j = 0; j < N; j++) begin
                            pix_q[j]  <= window[j*PIX_W +: PIX_W];
                            coef_q[j] <= kernel[j*COEF_W +: COEF_W];
                        end
                        shift_q <= shift;
                        acc     <= '0;
                        idx     <= '0;
                        cnt     <= CNT_W'(C - 1);
                    end
                end
                ACCUM: begin
                    acc <= acc + lane_sum;
                    idx <= idx + IDX_W'(LANES);
                    if (!last_tap) cnt <= cnt - CNT_W'(1);
                end
                NORM: begin
                    out_pixel <= norm_pixel;
                    overflow  <= norm_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_engine.sv
// Bench for conv_kernel_engine: a LANES=1 and a LANES=3 instance share stimulus and
// are checked every cycle against a sum-of-products model plus literal expectations.
module tb_conv_kernel_engine;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [71:0] window = '0;
    logic [71:0] kernel = '0;
    logic [3:0]  shift = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, overflow_a, busy_a;
    logic       in_ready_b, out_valid_b, overflow_b, busy_b;
    logic [7:0] out_pixel_a, out_pixel_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_kernel_engine #(.SIZE(3), .PIX_W(8), .COEF_W(8), .LANES(1)) dut_a (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .window(window), .kernel(kernel), .shift(shift), .clear(clear),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pixel(out_pixel_a),
        .overflow(overflow_a), .busy(busy_a)
    );

    conv_kernel_engine #(.SIZE(3), .PIX_W(8), .COEF_W(8), .LANES(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .window(window), .kernel(kernel), .shift(shift), .clear(clear),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pixel(out_pixel_b),
        .overflow(overflow_b), .busy(busy_b)
    );

    logic       ovl [2];
    logic       ofl [2];
    logic       bsy [2];
    logic       rdy [2];
    logic [7:0] opx [2];
    assign ovl[0] = out_valid_a;  assign ovl[1] = out_valid_b;
    assign ofl[0] = overflow_a;   assign ofl[1] = overflow_b;
    assign bsy[0] = busy_a;       assign bsy[1] = busy_b;
    assign rdy[0] = in_ready_a;   assign rdy[1] = in_ready_b;
    assign opx[0] = out_pixel_a;  assign opx[1] = out_pixel_b;

    // Handshake-to-valid latency is ceil(9/LANES)+1
    int lat [2] = '{10, 4};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [71:0] w, input logic [71:0] k,
                                  input logic [3:0] sh, output logic [7:0] px,
                                  output logic ov);
        longint sum, s, p, c;
        sum = 0;
        for (int j = 0; j < 9; j++) begin
            p = longint'(w[j*8 +: 8]);
            c = longint'($signed(k[j*8 +: 8]));
            sum += p * c;
        end
        s = sum >>> sh;
        if (s < 0) begin
            px = 8'd0;   ov = 1'b1;
        end else if (s > 255) begin
            px = 8'd255; ov = 1'b1;
        end else begin
            px = s[7:0]; ov = 1'b0;
        end
    endfunction

    logic       pend [2] = '{1'b0, 1'b0};
    logic       seen [2] = '{1'b0, 1'b0};
    int         acc_edge [2] = '{0, 0};
    logic [7:0] exp_pix [2] = '{8'd0, 8'd0};
    logic       exp_ovf [2] = '{1'b0, 1'b0};
    logic [7:0] hold_pix [2] = '{8'd0, 8'd0};
    logic       hold_ovf [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!n_rst) begin
                chk("rst_out_valid", longint'(ovl[d]), 0);
                chk("rst_out_pixel", longint'(opx[d]), 0);
                chk("rst_overflow", longint'(ofl[d]), 0);
                chk("rst_busy", longint'(bsy[d]), 0);
                pend[d] = 1'b0;
                hold_pix[d] = 8'd0;
                hold_ovf[d] = 1'b0;
            end else begin
                chk("ready_vs_busy", longint'(rdy[d]), longint'(!bsy[d]));
                if (ovl[d]) begin
                    chk("out_valid_expected", longint'(pend[d]), 1);
                    if (pend[d]) begin
                        if (!seen[d]) begin
                            chk("model_latency", longint'(cyc - acc_edge[d]), longint'(lat[d]));
                            seen[d] = 1'b1;
                        end
                        chk("model_pixel", longint'(opx[d]), longint'(exp_pix[d]));
                        chk("model_overflow", longint'(ofl[d]), longint'(exp_ovf[d]));
                        hold_pix[d] = exp_pix[d];
                        hold_ovf[d] = exp_ovf[d];
                        if (out_ready) pend[d] = 1'b0;
                    end
                end else begin
                    chk("held_pixel", longint'(opx[d]), longint'(hold_pix[d]));
                    chk("held_overflow", longint'(ofl[d]), longint'(hold_ovf[d]));
                end
                if (clear) begin
                    pend[d] = 1'b0;
                    hold_ovf[d] = 1'b0;
                end else if (in_valid && rdy[d]) begin
                    model(window, kernel, shift, exp_pix[d], exp_ovf[d]);
                    pend[d] = 1'b1;
                    seen[d] = 1'b0;
                    acc_edge[d] = cyc + 1;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_a || busy_b) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [71:0] w, input logic [71:0] k, input logic [3:0] sh);
        @(posedge clk); #1;
        in_valid = 1'b1; window = w; kernel = k; shift = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc = cyc;
        for (int j = 0; j < 9; j++) begin
            window[j*8 +: 8] = 8'($urandom);
            kernel[j*8 +: 8] = 8'($urandom);
        end
        shift = 4'($urandom);
    endtask

    task automatic wait_valid(input int d, input logic [7:0] px, input logic ov);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ovl[d] && n < 100);
        if (!ovl[d]) chk("valid_timeout", 0, 1);
        else begin
            chk("lit_latency", longint'(cyc - t_acc), longint'(lat[d]));
            chk("lit_pixel", longint'(opx[d]), longint'(px));
            chk("lit_overflow", longint'(ofl[d]), longint'(ov));
        end
    endtask

    task automatic op(input logic [71:0] w, input logic [71:0] k, input logic [3:0] sh,
                      input logic [7:0] px, input logic ov);
        wait_idle();
        send(w, k, sh);
        wait_valid(1, px, ov);
        wait_valid(0, px, ov);
        wait_idle();
    endtask

    localparam logic [71:0] W_ALL9   = {9{8'h09}};
    localparam logic [71:0] K_ONES   = {9{8'h01}};
    localparam logic [71:0] W_ALL16  = {9{8'h10}};
    localparam logic [71:0] K_GAUSS  = 72'h01_02_01_02_04_02_01_02_01;
    localparam logic [71:0] K_LAPL   = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;
    localparam logic [71:0] W_CTR    = 72'h00_00_00_00_FF_00_00_00_00;
    localparam logic [71:0] W_RING   = 72'hFF_FF_FF_FF_00_FF_FF_FF_FF;
    localparam logic [71:0] W_RAMP   = 72'h5A_50_46_3C_32_28_1E_14_0A;
    localparam logic [71:0] K_MIXED  = 72'h05_FC_04_FD_03_FE_02_FF_01;
    localparam logic [71:0] W_MAX    = {9{8'hFF}};
    localparam logic [71:0] K_MIN    = {9{8'h80}};
    localparam logic [71:0] K_MAX    = {9{8'h7F}};

    initial begin
        #1 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready_a", longint'(in_ready_a), 1);
        chk("reset_out_valid_a", longint'(out_valid_a), 0);
        n_rst = 1'b1;

        op(W_ALL9, K_ONES, 4'd0, 8'd81, 1'b0);
        op(W_ALL16, K_GAUSS, 4'd4, 8'd16, 1'b0);
        op(W_CTR, K_LAPL, 4'd0, 8'd255, 1'b1);
        op(W_RING, K_LAPL, 4'd0, 8'd0, 1'b1);
        op(W_RAMP, K_MIXED, 4'd1, 8'd175, 1'b0);
        op(W_MAX, K_MAX, 4'd15, 8'd8, 1'b0);
        op(W_MAX, K_MIN, 4'd15, 8'd0, 1'b1);

        // Backpressure: result must sit still while out_ready is low
        out_ready = 1'b0;
        send(W_ALL16, K_GAUSS, 4'd4);
        wait_valid(1, 8'd16, 1'b0);
        wait_valid(0, 8'd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid_a", longint'(out_valid_a), 1);
            chk("stall_pixel_a", longint'(out_pixel_a), 16);
            chk("stall_in_ready_a", longint'(in_ready_a), 0);
            chk("stall_in_ready_b", longint'(in_ready_b), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready_a", longint'(in_ready_a), 1);
        chk("release_out_valid_a", longint'(out_valid_a), 0);

        // Abort on the fourth ACCUM cycle of the LANES=1 engine with a competing request
        wait_idle();
        send(W_CTR, K_LAPL, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1; in_valid = 1'b1; window = W_ALL9; kernel = K_ONES; shift = 4'd0;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_busy_a", longint'(busy_a), 0);
        chk("clear_busy_b", longint'(busy_b), 0);
        chk("clear_overflow_a", longint'(overflow_a), 0);
        repeat (15) @(negedge clk);
        chk("clear_no_output_a", longint'(out_valid_a), 0);
        op(W_ALL9, K_ONES, 4'd0, 8'd81, 1'b0);

        // Reset while results are being presented
        out_ready = 1'b0;
        send(W_ALL16, K_GAUSS, 4'd4);
        wait_valid(1, 8'd16, 1'b0);
        wait_valid(0, 8'd16, 1'b0);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_valid_a", longint'(out_valid_a), 0);
        chk("rst_mid_pixel_a", longint'(out_pixel_a), 0);
        chk("rst_mid_busy_a", longint'(busy_a), 0);
        chk("rst_mid_valid_b", longint'(out_valid_b), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        out_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_no_output_a", longint'(out_valid_a), 0);
        op(W_RAMP, K_MIXED, 4'd1, 8'd175, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
